sound_mixer_accum: RTL and testbench
====================================

// Module: sound_mixer_accum
// PURPOSE
//  Time-multiplexed audio mixer sitting directly downstream of the noise sources (noise_shell,
//  noise_explo) and the other per-effect sound generators. On each sample strobe: snapshots
//  NCH unsigned 16-bit channels, scales each by a 4-bit gain, sums, saturates and applies a
//  one-pole low-pass. Produces one 16-bit unsigned sample per strobe for the audio DAC/top level.
// PARAMETERS
//  NCH        4  number of input channels (2..16)
//  GAIN_SHIFT 3  gain is value/2^GAIN_SHIFT; gain 8 = unity
//  FILT_K     0  low-pass shift; y += (x-y)>>>FILT_K; 0 = bypass (y = x)
// PORTS
//  clk           in   1        system clock; single clock domain
//  reset         in   1        synchronous, active-high
//  sample_en     in   1        one-clk sample strobe (e.g. 48 kHz enable)
//  sound_enable  in   1        0 = mute output (filter keeps running)
//  ch_in         in   NCH*16   channel i = ch_in[16*i+15:16*i], unsigned
//  ch_gain       in   NCH*4    channel i = ch_gain[4*i+3:4*i], unsigned 0..15
//  audio_out     out  16       mixed sample, unsigned, held between samples
//  sample_valid  out  1        1-clk pulse when audio_out updates
//  busy          out  1        high in any state other than IDLE
//  overrun       out  1        sticky; strobe arrived while busy; cleared only by reset
// BEHAVIOUR
//  - Reset, sampled on the clk edge: state=IDLE, idx=0, acc=0, filter y=0, audio_out=0,
//    sample_valid=0, busy=0, overrun=0. A reset during any state aborts the mix;
//    no sample_valid pulse is produced for the aborted sample.
//  - FSM: IDLE -> ACC -> SAT -> FILT -> OUT -> IDLE.
//  - IDLE: on sample_en=1, register a snapshot of ch_in and ch_gain, acc=0, idx=0, go to ACC.
//    Input changes after the snapshot edge do not affect the current sample.
//  - ACC: one channel per clk: acc += snap_ch[idx]*snap_gain[idx]; idx++.
//    After idx=NCH-1, go to SAT. ACC lasts exactly NCH clks.
//  - acc width: 16+4+clog2(NCH) bits, so it never wraps.
//  - SAT: m = acc >> GAIN_SHIFT (truncate); if m > 16'hFFFF then m = 16'hFFFF.
//  - FILT: d = {1'b0,m} - {1'b0,y}, computed as 17-bit signed; y = y + (d >>> FILT_K).
//    Result is always within 0..FFFF (no extra clamp needed). FILT_K=0 gives y=m.
//  - OUT: audio_out = sound_enable ? y : 0; sample_valid=1 for this one clk; go to IDLE.
//  - Latency: strobe sampled at edge E0; audio_out and sample_valid are registered at
//    edge E(NCH+3). Minimum strobe spacing is NCH+4 clks.
//  - sample_en=1 while busy: strobe ignored, overrun set to 1. sample_en in the same clk as
//    OUT is also ignored; it is accepted only in IDLE.
//  - sample_en is ignored in IDLE while reset=1.
//  - Mute does not freeze the filter: y keeps tracking m. On unmute, the next OUT shows the
//    current y.
//  - sample_valid is 0 in every clk except OUT.
// STRUCTURE
//  - Shared package: FSM state enum (S_IDLE,S_ACC,S_SAT,S_FILT,S_OUT), SAMPLE_W=16, GAIN_W=4,
//    and the acc-width function.
//  - One sub-module, audio_onepole_lpf (parameter K): combinational next-y from m and y,
//    with the y register enabled in FILT. Reusable by other audio paths.
//  - The channel mux and the 16x4 multiply stay inline: a single multiplier shared across
//    channels.
// TESTING (NCH=4, GAIN_SHIFT=3; FILT_K=0 unless stated)
//  1. Assert reset for 2 clks -> audio_out=0, sample_valid=0, busy=0, overrun=0.
//  2. ch0=16'h1000 gain 8, other channels 0, strobe -> 7 edges later audio_out=16'h1000,
//     sample_valid high for exactly 1 clk.
//  3. All ch=16'hFFFF, gain 15, strobe -> audio_out=16'hFFFF (saturated).
//     ch0=16'h0100 gain 4 plus ch1=16'h0100 gain 4 -> audio_out=16'h0100.
//  4. FILT_K=2 build, ch0 step to 16'h8000 gain 8, three strobes ->
//     audio_out = 16'h2000, then 16'h3800, then 16'h4A00.
//  5. Second strobe 3 clks after the first -> only one sample_valid, overrun=1 and stays 1.
//     Change ch_in during ACC -> result uses the snapshotted values.
//  6. Mute: sound_enable=0 -> audio_out=0 on valid. Re-enable with FILT_K=2 -> output is the
//     advanced filter value. Reset asserted mid-ACC -> busy=0 next clk, no sample_valid.

Source files
------------

// File: rtl/sound_mixer_accum_pkg.sv
// Shared definitions for the sound mixer and its sub-blocks.
//   mix_state_t : mixer sequencing states
//   SAMPLE_W    : audio sample width (unsigned)
//   GAIN_W      : per-channel gain width (unsigned)
//   acc_width() : accumulator width that cannot wrap for a given channel count
package sound_mixer_accum_pkg;

  localparam int SAMPLE_W = 16;
  localparam int GAIN_W   = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC,
    S_SAT,
    S_FILT,
    S_OUT
  } mix_state_t;

  // Full-scale sample times full-scale gain, summed over nch channels.
  function automatic int acc_width(input int nch);
    return SAMPLE_W + GAIN_W + $clog2(nch);
  endfunction

endpackage

// File: rtl/audio_onepole_lpf.sv
// One-pole low-pass filter: y <= y + ((m - y) >>> K), updated when en is high.
//   clk   : clock
//   reset : synchronous active-high, clears y to 0
//   en    : load the next filter value this clock
//   m     : new unsigned input sample
//   y     : filter state / output, unsigned
// K = 0 makes the filter transparent (y takes m on every enabled clock).
module audio_onepole_lpf
  import sound_mixer_accum_pkg::*;
#(
  parameter int K = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] m,
  output logic [SAMPLE_W-1:0] y
);

  logic [SAMPLE_W-1:0] y_reg;
  logic signed [SAMPLE_W:0] d;
  logic [SAMPLE_W-1:0] y_next;

  // One extra bit keeps the difference signed. The arithmetic shift rounds toward
  // minus infinity, so the step never overshoots m and the sum stays in 0..FFFF,
  // which makes dropping the top bit safe.
  assign d      = $signed({1'b0, m}) - $signed({1'b0, y_reg});
  assign y_next = SAMPLE_W'($signed({1'b0, y_reg}) + (d >>> K));

  always_ff @(posedge clk) begin
    if (reset) begin
      y_reg <= '0;
    end else if (en) begin
      y_reg <= y_next;
    end
  end

  assign y = y_reg;

endmodule

// File: rtl/sound_mixer_accum.sv
// Time-multiplexed audio mixer. A sample strobe snapshots NCH channels and gains;
// one shared multiplier accumulates channel*gain one channel per clock, the sum is
// scaled by 2^-GAIN_SHIFT and saturated, then passed through a one-pole low-pass.
//   clk          : clock
//   reset        : synchronous active-high; aborts any mix in progress
//   sample_en    : one-clock sample strobe, accepted only when idle
//   sound_enable : 0 mutes audio_out (filter keeps tracking)
//   ch_in        : NCH x 16-bit unsigned channels, channel i at [16*i +: 16]
//   ch_gain      : NCH x 4-bit unsigned gains, channel i at [4*i +: 4]
//   audio_out    : mixed sample, held between updates
//   sample_valid : one-clock pulse when audio_out updates
//   busy         : mixer is not idle
//   overrun      : sticky, a strobe arrived while busy
module sound_mixer_accum
  import sound_mixer_accum_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int GAIN_SHIFT = 3,
  parameter int FILT_K     = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_en,
  input  logic                       sound_enable,
  input  logic [NCH*SAMPLE_W-1:0]    ch_in,
  input  logic [NCH*GAIN_W-1:0]      ch_gain,
  output logic [SAMPLE_W-1:0]        audio_out,
  output logic                       sample_valid,
  output logic                       busy,
  output logic                       overrun
);

  localparam int ACC_W  = acc_width(NCH);
  localparam int IDX_W  = $clog2(NCH);
  localparam int PROD_W = SAMPLE_W + GAIN_W;

  mix_state_t state_reg, state_next;

  logic [IDX_W-1:0]    idx_reg;
  logic [ACC_W-1:0]    acc_reg;
  logic [SAMPLE_W-1:0] m_reg;
  logic [SAMPLE_W-1:0] audio_out_reg;
  logic                sample_valid_reg;
  logic                overrun_reg;

  logic [SAMPLE_W-1:0] ch_slice      [NCH];
  logic [GAIN_W-1:0]   gain_slice    [NCH];
  logic [SAMPLE_W-1:0] snap_ch_reg   [NCH];
  logic [GAIN_W-1:0]   snap_gain_reg [NCH];

  logic [PROD_W-1:0]   prod;
  logic [ACC_W-1:0]    acc_scaled;
  logic [SAMPLE_W-1:0] m_next;
  logic [SAMPLE_W-1:0] y_filt;
  logic                accept;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
    assign ch_slice[gi]   = ch_in[gi*SAMPLE_W +: SAMPLE_W];
    assign gain_slice[gi] = ch_gain[gi*GAIN_W +: GAIN_W];
  end

  assign accept = (state_reg == S_IDLE) && sample_en;

  // Channel mux into the single shared multiplier.
  assign prod = PROD_W'(snap_ch_reg[idx_reg]) * PROD_W'(snap_gain_reg[idx_reg]);

  // Truncating scale, then clamp anything above 16 bits to full scale.
  assign acc_scaled = acc_reg >> GAIN_SHIFT;
  assign m_next     = (|acc_scaled[ACC_W-1:SAMPLE_W]) ? {SAMPLE_W{1'b1}}
                                                      : acc_scaled[SAMPLE_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE:  if (sample_en) state_next = S_ACC;
      S_ACC:   if (idx_reg == IDX_W'(NCH - 1)) state_next = S_SAT;
      S_SAT:   state_next = S_FILT;
      S_FILT:  state_next = S_OUT;
      S_OUT:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Snapshot is plain data; it is only consumed after a fresh capture.
  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      snap_ch_reg   <= ch_slice;
      snap_gain_reg <= gain_slice;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_reg          <= '0;
      acc_reg          <= '0;
      m_reg            <= '0;
      audio_out_reg    <= '0;
      sample_valid_reg <= 1'b0;
      overrun_reg      <= 1'b0;
    end else begin
      sample_valid_reg <= 1'b0;
      if (sample_en && (state_reg != S_IDLE)) begin
        overrun_reg <= 1'b1;
      end
      unique case (state_reg)
        S_IDLE: begin
          if (sample_en) begin
            acc_reg <= '0;
            idx_reg <= '0;
          end
        end
        S_ACC: begin
          acc_reg <= acc_reg + ACC_W'(prod);
          idx_reg <= idx_reg + 1'b1;
        end
        S_SAT: begin
          m_reg <= m_next;
        end
        S_OUT: begin
          audio_out_reg    <= sound_enable ? y_filt : '0;
          sample_valid_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  audio_onepole_lpf #(
    .K (FILT_K)
  ) u_lpf (
    .clk   (clk),
    .reset (reset),
    .en    (state_reg == S_FILT),
    .m     (m_reg),
    .y     (y_filt)
  );

  assign audio_out    = audio_out_reg;
  assign sample_valid = sample_valid_reg;
  assign busy         = (state_reg != S_IDLE);
  assign overrun      = overrun_reg;

endmodule

// File: tb/tb_sound_mixer_accum.sv
// Self-checking bench for sound_mixer_accum. Two instances share all inputs:
// dut0 with the filter bypassed and dut2 with a K=2 low-pass.
module tb_sound_mixer_accum;

  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_en = 1'b0;
  logic        sound_enable = 1'b1;
  logic [63:0] ch_in = '0;
  logic [15:0] ch_gain = '0;

  logic [15:0] out0, out2;
  logic        v0, v2, busy0, busy2, ovr0, ovr2;

  int total = 0;
  int bad   = 0;
  int y_model = 0;

  always #5 clk = ~clk;

  sound_mixer_accum #(.NCH(NCH), .GAIN_SHIFT(3), .FILT_K(0)) dut0 (
    .clk(clk), .reset(reset), .sample_en(sample_en), .sound_enable(sound_enable),
    .ch_in(ch_in), .ch_gain(ch_gain), .audio_out(out0), .sample_valid(v0),
    .busy(busy0), .overrun(ovr0)
  );

  sound_mixer_accum #(.NCH(NCH), .GAIN_SHIFT(3), .FILT_K(2)) dut2 (
    .clk(clk), .reset(reset), .sample_en(sample_en), .sound_enable(sound_enable),
    .ch_in(ch_in), .ch_gain(ch_gain), .audio_out(out2), .sample_valid(v2),
    .busy(busy2), .overrun(ovr2)
  );

  // Reference: weighted sum, divide by 8 (truncate), clamp to 16 bits.
  function automatic int mix_model(input logic [63:0] ch, input logic [15:0] g);
    longint s = 0;
    for (int i = 0; i < NCH; i++) s += longint'(ch[16*i +: 16]) * longint'(g[4*i +: 4]);
    s = s / 8;
    if (s > 65535) s = 65535;
    return int'(s);
  endfunction

  // Reference: y moves a quarter of the way toward m, rounding toward minus infinity.
  function automatic int filt_model(input int y, input int m);
    int d = m - y;
    int q = (d >= 0) ? d / 4 : -((-d + 3) / 4);
    return y + q;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    sample_en = 1'b1;   // must be ignored while reset is high
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sample_en = 1'b0;
    y_model = 0;
  endtask

  // Pulse the strobe, then wait (bounded) for the output pulse. lat counts edges after E0.
  task automatic do_strobe(output int lat, output logic [15:0] a0, output logic [15:0] a2);
    lat = -1; a0 = '0; a2 = '0;
    @(negedge clk);
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (v0) begin
        lat = k; a0 = out0; a2 = out2;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    total++; if (out0 !== 16'h0) begin bad++; $display("FAIL reset_audio: got %h want 0000", out0); end
    total++; if (v0 !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", v0); end
    total++; if (busy0 !== 1'b0 || busy2 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b/%b want 0/0", busy0, busy2); end
    total++; if (ovr0 !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", ovr0); end
  endtask

  task automatic test_single();
    int lat; logic [15:0] a0, a2; int m;
    sound_enable = 1'b1;
    ch_in = 64'h0000_0000_0000_1000;
    ch_gain = 16'h0008;
    do_strobe(lat, a0, a2);
    m = mix_model(ch_in, ch_gain);
    y_model = filt_model(y_model, m);
    total++; if (lat != 7) begin bad++; $display("FAIL single_latency: got %0d want 7", lat); end
    total++; if (a0 !== 16'h1000) begin bad++; $display("FAIL single_audio: got %h want 1000", a0); end
    total++; if (a2 !== 16'(y_model)) begin bad++; $display("FAIL single_filt: got %h want %h", a2, 16'(y_model)); end
    @(negedge clk);
    total++; if (v0 !== 1'b0) begin bad++; $display("FAIL single_pulse_width: got %b want 0", v0); end
  endtask

  task automatic test_saturate();
    int lat; logic [15:0] a0, a2; int m;
    ch_in = {4{16'hFFFF}};
    ch_gain = 16'hFFFF;
    do_strobe(lat, a0, a2);
    m = mix_model(ch_in, ch_gain);
    y_model = filt_model(y_model, m);
    total++; if (a0 !== 16'hFFFF) begin bad++; $display("FAIL sat_full: got %h want ffff", a0); end
    total++; if (a2 !== 16'(y_model)) begin bad++; $display("FAIL sat_filt: got %h want %h", a2, 16'(y_model)); end
    ch_in = 64'h0000_0000_0100_0100;
    ch_gain = 16'h0044;
    do_strobe(lat, a0, a2);
    m = mix_model(ch_in, ch_gain);
    y_model = filt_model(y_model, m);
    total++; if (a0 !== 16'h0100) begin bad++; $display("FAIL sat_two_ch: got %h want 0100", a0); end
  endtask

  task automatic test_filter();
    int lat; logic [15:0] a0, a2;
    logic [15:0] exp_tab [3];
    exp_tab = '{16'h2000, 16'h3800, 16'h4A00};
    apply_reset();
    sound_enable = 1'b1;
    ch_in = 64'h0000_0000_0000_8000;
    ch_gain = 16'h0008;
    for (int i = 0; i < 3; i++) begin
      do_strobe(lat, a0, a2);
      y_model = filt_model(y_model, mix_model(ch_in, ch_gain));
      total++; if (a2 !== exp_tab[i]) begin bad++; $display("FAIL filt_step%0d: got %h want %h", i, a2, exp_tab[i]); end
      total++; if (a0 !== 16'h8000) begin bad++; $display("FAIL filt_bypass%0d: got %h want 8000", i, a0); end
    end
  endtask

  task automatic test_random();
    int lat; logic [15:0] a0, a2; int m;
    logic [15:0] e0, e2;
    for (int i = 0; i < 24; i++) begin
      ch_in = {$urandom, $urandom};
      ch_gain = 16'($urandom);
      if (i % 3 == 0) ch_in = ch_in >> $urandom_range(0, 40);
      sound_enable = ($urandom_range(0, 3) != 0);
      do_strobe(lat, a0, a2);
      m = mix_model(ch_in, ch_gain);
      y_model = filt_model(y_model, m);
      e0 = sound_enable ? 16'(m) : 16'h0;
      e2 = sound_enable ? 16'(y_model) : 16'h0;
      total++; if (lat != 7) begin bad++; $display("FAIL rand%0d_latency: got %0d want 7", i, lat); end
      total++; if (a0 !== e0) begin bad++; $display("FAIL rand%0d_audio: got %h want %h", i, a0, e0); end
      total++; if (a2 !== e2) begin bad++; $display("FAIL rand%0d_filt: got %h want %h", i, a2, e2); end
    end
    sound_enable = 1'b1;
  endtask

  task automatic test_overrun();
    int cnt = 0; int lat; logic [15:0] a0 = '0, a2 = '0;
    sound_enable = 1'b1;
    ch_in = 64'h0000_0000_0000_1000;
    ch_gain = 16'h0008;
    @(negedge clk); sample_en = 1'b1;
    @(negedge clk); sample_en = 1'b0;           // after E0
    y_model = filt_model(y_model, mix_model(ch_in, ch_gain));
    @(negedge clk);                             // after E1: inputs change mid-ACC
    ch_in = {4{16'hFFFF}};
    ch_gain = 16'hFFFF;
    @(negedge clk); sample_en = 1'b1;           // second strobe lands on E3
    @(negedge clk); sample_en = 1'b0;
    for (int k = 4; k <= 24; k++) begin
      @(negedge clk);
      if (v0) begin cnt++; a0 = out0; a2 = out2; end
    end
    total++; if (cnt != 1) begin bad++; $display("FAIL ovr_valid_count: got %0d want 1", cnt); end
    total++; if (a0 !== 16'h1000) begin bad++; $display("FAIL ovr_snapshot: got %h want 1000", a0); end
    total++; if (a2 !== 16'(y_model)) begin bad++; $display("FAIL ovr_filt: got %h want %h", a2, 16'(y_model)); end
    total++; if (ovr0 !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b want 1", ovr0); end
    ch_in = 64'h0000_0000_0200_0000;
    ch_gain = 16'h0080;
    do_strobe(lat, a0, a2);
    y_model = filt_model(y_model, mix_model(ch_in, ch_gain));
    total++; if (a0 !== 16'h0200) begin bad++; $display("FAIL ovr_next_audio: got %h want 0200", a0); end
    total++; if (ovr0 !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %b want 1", ovr0); end
  endtask

  task automatic test_mute();
    int lat; logic [15:0] a0, a2;
    ch_in = 64'h0000_0000_0000_C000;
    ch_gain = 16'h0008;
    sound_enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      do_strobe(lat, a0, a2);
      y_model = filt_model(y_model, mix_model(ch_in, ch_gain));
      total++; if (a0 !== 16'h0 || a2 !== 16'h0) begin bad++; $display("FAIL mute%0d: got %h/%h want 0000/0000", i, a0, a2); end
    end
    sound_enable = 1'b1;
    do_strobe(lat, a0, a2);
    y_model = filt_model(y_model, mix_model(ch_in, ch_gain));
    total++; if (a2 !== 16'(y_model)) begin bad++; $display("FAIL unmute_filt: got %h want %h", a2, 16'(y_model)); end
    total++; if (a0 !== 16'hC000) begin bad++; $display("FAIL unmute_audio: got %h want c000", a0); end
  endtask

  task automatic test_reset_mid();
    int cnt = 0; int lat; logic [15:0] a0, a2;
    ch_in = 64'h0000_0000_0000_4000;
    ch_gain = 16'h0008;
    @(negedge clk); sample_en = 1'b1;
    @(negedge clk); sample_en = 1'b0;
    total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %b want 1", busy0); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    y_model = 0;
    total++; if (busy0 !== 1'b0 || busy2 !== 1'b0) begin bad++; $display("FAIL mid_busy_after: got %b/%b want 0/0", busy0, busy2); end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (v0 || v2) cnt++;
    end
    total++; if (cnt != 0) begin bad++; $display("FAIL mid_no_valid: got %0d want 0", cnt); end
    total++; if (ovr0 !== 1'b0 || out0 !== 16'h0) begin bad++; $display("FAIL mid_cleared: got ovr=%b out=%h want 0/0000", ovr0, out0); end
    do_strobe(lat, a0, a2);
    y_model = filt_model(y_model, mix_model(ch_in, ch_gain));
    total++; if (a2 !== 16'(y_model)) begin bad++; $display("FAIL mid_restart_filt: got %h want %h", a2, 16'(y_model)); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturate();
    test_filter();
    test_random();
    test_overrun();
    test_mute();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
